// File: rtl/alu_op_arbiter.sv
// -----------------------------------------------------------------------------
// alu_op_arbiter
//
// Shares a single ALU datapath between two requesters (A and B). A round-robin
// arbiter picks one pending operation while idle, the operation is latched and
// evaluated for one cycle, and the result is held as a registered response
// until the consumer takes it. A sticky overflow bit accumulates signed
// overflow from completed add/sub operations for software to inspect.
//
// Ports
//   clk, rst_n               clock (rising edge), asynchronous active-low reset
//   a_valid/a_ready          requester A handshake
//   a_op, a_x, a_y           requester A select code and operands
//   b_valid/b_ready          requester B handshake
//   b_op, b_x, b_y           requester B select code and operands
//   rsp_valid/rsp_ready      response handshake
//   rsp_id                   originating requester (0 = A, 1 = B)
//   rsp_result, rsp_ovf      registered result and signed-overflow flag
//   alu_sel                  select code presented to the ALU (000 when idle)
//   ovf_sticky, ovf_clr      accumulated overflow status and its clear
//
// Select codes
//   000 add   001 sub   010 and   011 or
//   100 xor   101 not x 110 signed x<y   111 pass x
// -----------------------------------------------------------------------------
module alu_op_arbiter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             a_valid,
    output logic             a_ready,
    input  logic [2:0]       a_op,
    input  logic [WIDTH-1:0] a_x,
    input  logic [WIDTH-1:0] a_y,

    input  logic             b_valid,
    output logic             b_ready,
    input  logic [2:0]       b_op,
    input  logic [WIDTH-1:0] b_x,
    input  logic [WIDTH-1:0] b_y,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_ovf,

    output logic [2:0]       alu_sel,
    output logic             ovf_sticky,
    input  logic             ovf_clr
);

    localparam int unsigned MSB = WIDTH - 1;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_NOT  = 3'b101;
    localparam logic [2:0] OP_SLT  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t             state_q;
    logic               lastGrant_q;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   x_q;
    logic [WIDTH-1:0]   y_q;
    logic               id_q;

    logic               rspValid_q;
    logic               rspId_q;
    logic [WIDTH-1:0]   rspResult_q;
    logic               rspOvf_q;
    logic [2:0]         aluSel_q;
    logic               ovfSticky_q;

    logic               grantA_d;
    logic               grantB_d;
    logic [WIDTH-1:0]   result_d;
    logic               ovf_d;

    // Grants are only offered while idle. With both requesters pending, the
    // one that did not win last time gets the slot. Gating with rst_n keeps
    // both readies low while reset is held, even if a requester is waiting.
    always_comb begin
        grantA_d = 1'b0;
        grantB_d = 1'b0;
        if (rst_n && (state_q == IDLE)) begin
            if (a_valid && b_valid) begin
                if (lastGrant_q == REQ_B) begin
                    grantA_d = 1'b1;
                end else begin
                    grantB_d = 1'b1;
                end
            end else if (a_valid) begin
                grantA_d = 1'b1;
            end else if (b_valid) begin
                grantB_d = 1'b1;
            end
        end
    end

    assign a_ready = grantA_d;
    assign b_ready = grantB_d;

    // ALU evaluated on the latched operation; only meaningful in EXEC, where
    // it is captured into the response registers.
    always_comb begin
        result_d = '0;
        ovf_d    = 1'b0;
        case (op_q)
            OP_ADD: begin
                result_d = x_q + y_q;
                // Same-sign operands producing a result of the other sign.
                ovf_d = (x_q[MSB] == y_q[MSB]) && (result_d[MSB] != x_q[MSB]);
            end
            OP_SUB: begin
                result_d = x_q - y_q;
                // Opposite-sign operands where the result leaves x's sign.
                ovf_d = (x_q[MSB] != y_q[MSB]) && (result_d[MSB] != x_q[MSB]);
            end
            OP_AND:  result_d = x_q & y_q;
            OP_OR:   result_d = x_q | y_q;
            OP_XOR:  result_d = x_q ^ y_q;
            OP_NOT:  result_d = ~x_q;
            OP_SLT:  result_d[0] = ($signed(x_q) < $signed(y_q));
            OP_PASS: result_d = x_q;
            default: result_d = '0;
        endcase
    end

    // Control FSM with all externally visible outputs registered. The sticky
    // clear is applied first so that a completing overflow later in the same
    // block takes priority over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lastGrant_q <= REQ_B;
            op_q        <= 3'b000;
            x_q         <= '0;
            y_q         <= '0;
            id_q        <= REQ_A;
            rspValid_q  <= 1'b0;
            rspId_q     <= 1'b0;
            rspResult_q <= '0;
            rspOvf_q    <= 1'b0;
            aluSel_q    <= 3'b000;
            ovfSticky_q <= 1'b0;
        end else begin
            if (ovf_clr) begin
                ovfSticky_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (grantA_d || grantB_d) begin
                        op_q        <= grantB_d ? b_op : a_op;
                        x_q         <= grantB_d ? b_x  : a_x;
                        y_q         <= grantB_d ? b_y  : a_y;
                        aluSel_q    <= grantB_d ? b_op : a_op;
                        id_q        <= grantB_d;
                        lastGrant_q <= grantB_d;
                        state_q     <= EXEC;
                    end
                end

                EXEC: begin
                    rspResult_q <= result_d;
                    rspOvf_q    <= ovf_d;
                    rspId_q     <= id_q;
                    rspValid_q  <= 1'b1;
                    if (ovf_d) begin
                        ovfSticky_q <= 1'b1;
                    end
                    state_q     <= RESP;
                end

                RESP: begin
                    // Response registers are left untouched here so they stay
                    // stable for as long as the consumer stalls.
                    if (rsp_ready) begin
                        rspValid_q <= 1'b0;
                        aluSel_q   <= 3'b000;
                        state_q    <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid  = rspValid_q;
    assign rsp_id     = rspId_q;
    assign rsp_result = rspResult_q;
    assign rsp_ovf    = rspOvf_q;
    assign alu_sel    = aluSel_q;
    assign ovf_sticky = ovfSticky_q;

endmodule

// File: tb/tb_alu_op_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_op_arbiter
//
// Self-checking bench for alu_op_arbiter (WIDTH = 8). Directed sequences cover
// reset, overflow reporting, the sticky flag, arbitration fairness, response
// backpressure and reset during an operation; a vector table covers every
// select code; a randomized phase compares against an integer-arithmetic
// reference model with a transaction-level view of arbitration.
// -----------------------------------------------------------------------------
module tb_alu_op_arbiter;

    logic       clk;
    logic       rst_n;
    logic       a_valid, a_ready, b_valid, b_ready;
    logic [2:0] a_op, b_op, alu_sel;
    logic [7:0] a_x, a_y, b_x, b_y, rsp_result;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_ovf;
    logic       ovf_sticky, ovf_clr;

    int   checks = 0;
    int   errors = 0;
    logic lastGrantModel;
    logic stickyModel;

    typedef struct {
        logic [2:0] op;
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] expRes;
        logic       expOvf;
    } vec_t;

    vec_t vecs[15];

    alu_op_arbiter #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .a_op       (a_op),
        .a_x        (a_x),
        .a_y        (a_y),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .b_op       (b_op),
        .b_x        (b_x),
        .b_y        (b_y),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_ovf    (rsp_ovf),
        .alu_sel    (alu_sel),
        .ovf_sticky (ovf_sticky),
        .ovf_clr    (ovf_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic aV, input logic [2:0] aOp, input logic [7:0] aX, input logic [7:0] aY,
                                 input logic bV, input logic [2:0] bOp, input logic [7:0] bX, input logic [7:0] bY);
        a_valid = aV; a_op = aOp; a_x = aX; a_y = aY;
        b_valid = bV; b_op = bOp; b_x = bX; b_y = bY;
    endtask

    // Reference model in plain signed integer arithmetic.
    function automatic void refModel(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y,
                                     output logic [7:0] res, output logic ovf);
        int sx;
        int sy;
        int full;
        sx  = (x > 8'd127) ? int'(x) - 256 : int'(x);
        sy  = (y > 8'd127) ? int'(y) - 256 : int'(y);
        ovf = 1'b0;
        res = 8'h00;
        case (op)
            3'd0: begin full = sx + sy; res = 8'(full); ovf = (full > 127) || (full < -128); end
            3'd1: begin full = sx - sy; res = 8'(full); ovf = (full > 127) || (full < -128); end
            3'd2: res = x & y;
            3'd3: res = x | y;
            3'd4: res = x ^ y;
            3'd5: res = ~x;
            3'd6: res = (sx < sy) ? 8'd1 : 8'd0;
            default: res = x;
        endcase
    endfunction

    task automatic checkResetValues();
        checkOutput("rst_a_ready",    a_ready,    0);
        checkOutput("rst_b_ready",    b_ready,    0);
        checkOutput("rst_rsp_valid",  rsp_valid,  0);
        checkOutput("rst_rsp_id",     rsp_id,     0);
        checkOutput("rst_rsp_result", rsp_result, 0);
        checkOutput("rst_rsp_ovf",    rsp_ovf,    0);
        checkOutput("rst_alu_sel",    alu_sel,    0);
        checkOutput("rst_ovf_sticky", ovf_sticky, 0);
    endtask

    // Runs one operation from the point where requests are already driven
    // (called at a falling edge): handshake, EXEC, RESP with optional stall,
    // and acceptance. Optionally pulses ovf_clr on the completing edge.
    task automatic awaitTransaction(input logic expIdB, input logic [7:0] expRes, input logic expOvf,
                                    input logic expSticky, input logic [2:0] expSel, input int stall,
                                    input logic clrAtComplete);
        int waitCnt;
        waitCnt = 0;
        #1;
        while (!((a_valid && a_ready) || (b_valid && b_ready)) && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("handshake_wait", waitCnt, 0);
        if (waitCnt >= 20) return;
        checkOutput("grant_a", a_ready, !expIdB);
        checkOutput("grant_b", b_ready, expIdB);

        @(posedge clk); #1;
        if (expIdB) b_valid = 1'b0; else a_valid = 1'b0;
        lastGrantModel = expIdB;
        ovf_clr = clrAtComplete;

        @(negedge clk);
        checkOutput("exec_rsp_valid", rsp_valid, 0);
        checkOutput("exec_a_ready",   a_ready,   0);
        checkOutput("exec_b_ready",   b_ready,   0);
        checkOutput("exec_alu_sel",   alu_sel,   expSel);

        @(posedge clk); #1;
        ovf_clr = 1'b0;

        @(negedge clk);
        checkOutput("resp_valid",  rsp_valid,  1);
        checkOutput("resp_result", rsp_result, expRes);
        checkOutput("resp_ovf",    rsp_ovf,    expOvf);
        checkOutput("resp_id",     rsp_id,     expIdB);
        checkOutput("resp_sticky", ovf_sticky, expSticky);
        checkOutput("resp_alu_sel", alu_sel,   expSel);

        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            checkOutput("stall_valid",   rsp_valid,  1);
            checkOutput("stall_result",  rsp_result, expRes);
            checkOutput("stall_ovf",     rsp_ovf,    expOvf);
            checkOutput("stall_id",      rsp_id,     expIdB);
            checkOutput("stall_a_ready", a_ready,    0);
            checkOutput("stall_b_ready", b_ready,    0);
        end

        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        checkOutput("accept_rsp_valid", rsp_valid, 0);
        checkOutput("accept_alu_sel",   alu_sel,   0);
    endtask

    task automatic pulseClear();
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        @(negedge clk);
        checkOutput("sticky_clear", ovf_sticky, 0);
    endtask

    initial begin
        logic [7:0] res;
        logic       ovf;
        logic       pendV[2];
        logic [2:0] pendOp[2];
        logic [7:0] pendX[2];
        logic [7:0] pendY[2];
        logic       expB;
        logic       clr;

        vecs[0]  = '{3'b010, 8'hF0, 8'h3C, 8'h30, 1'b0};
        vecs[1]  = '{3'b011, 8'hF0, 8'h0F, 8'hFF, 1'b0};
        vecs[2]  = '{3'b100, 8'hAA, 8'hFF, 8'h55, 1'b0};
        vecs[3]  = '{3'b101, 8'h0F, 8'h12, 8'hF0, 1'b0};
        vecs[4]  = '{3'b110, 8'h80, 8'h01, 8'h01, 1'b0};
        vecs[5]  = '{3'b110, 8'h01, 8'h80, 8'h00, 1'b0};
        vecs[6]  = '{3'b110, 8'h05, 8'h05, 8'h00, 1'b0};
        vecs[7]  = '{3'b111, 8'h5A, 8'hC3, 8'h5A, 1'b0};
        vecs[8]  = '{3'b010, 8'h80, 8'h80, 8'h80, 1'b0};
        vecs[9]  = '{3'b000, 8'hFF, 8'h01, 8'h00, 1'b0};
        vecs[10] = '{3'b001, 8'h00, 8'h01, 8'hFF, 1'b0};
        vecs[11] = '{3'b000, 8'h80, 8'h80, 8'h00, 1'b1};
        vecs[12] = '{3'b001, 8'h7F, 8'hFF, 8'h80, 1'b1};
        vecs[13] = '{3'b000, 8'h7F, 8'h01, 8'h80, 1'b1};
        vecs[14] = '{3'b001, 8'h80, 8'h01, 8'h7F, 1'b1};

        rst_n = 1'b0;
        rsp_ready = 1'b0;
        ovf_clr = 1'b0;
        lastGrantModel = 1'b1;
        stickyModel = 1'b0;
        applyStimulus(1'b1, 3'b000, 8'h7F, 8'h01, 1'b0, 3'b000, 8'h00, 8'h00);

        // Reset values while A is already requesting.
        repeat (2) @(negedge clk);
        checkResetValues();

        // Add overflow straight after reset release.
        $display("[TB] add overflow after reset");
        rst_n = 1'b1;
        awaitTransaction(1'b0, 8'h80, 1'b1, 1'b1, 3'b000, 0, 1'b0);

        // Sub overflow, then a non-overflowing op; sticky held until cleared.
        $display("[TB] sub overflow and sticky hold");
        applyStimulus(1'b0, 3'b000, 8'h00, 8'h00, 1'b1, 3'b001, 8'h80, 8'h01);
        awaitTransaction(1'b1, 8'h7F, 1'b1, 1'b1, 3'b001, 0, 1'b0);
        applyStimulus(1'b0, 3'b000, 8'h00, 8'h00, 1'b1, 3'b010, 8'hF0, 8'h3C);
        awaitTransaction(1'b1, 8'h30, 1'b0, 1'b1, 3'b010, 0, 1'b0);
        pulseClear();

        // Every select code through the vector table.
        $display("[TB] vector table");
        stickyModel = 1'b0;
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1'b1, vecs[i].op, vecs[i].x, vecs[i].y, 1'b0, 3'b000, 8'h00, 8'h00);
            stickyModel = stickyModel | vecs[i].expOvf;
            awaitTransaction(1'b0, vecs[i].expRes, vecs[i].expOvf, stickyModel, vecs[i].op, 0, 1'b0);
        end

        // Sticky set and clear on the same edge: set wins.
        $display("[TB] sticky set/clear collision");
        pulseClear();
        applyStimulus(1'b1, 3'b000, 8'h40, 8'h40, 1'b0, 3'b000, 8'h00, 8'h00);
        awaitTransaction(1'b0, 8'h80, 1'b1, 1'b1, 3'b000, 0, 1'b1);

        // Reset while an operation is in EXEC.
        $display("[TB] reset mid-operation");
        applyStimulus(1'b1, 3'b001, 8'h80, 8'h01, 1'b0, 3'b000, 8'h00, 8'h00);
        #1;
        checkOutput("midop_a_ready", a_ready, 1);
        @(posedge clk); #1;
        a_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checkResetValues();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        lastGrantModel = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("post_reset_no_rsp", rsp_valid, 0);
        end
        rsp_ready = 1'b0;

        // Fairness: both requesting, A first after reset, then alternating.
        $display("[TB] fairness");
        for (int i = 0; i < 4; i++) begin
            expB = (i % 2 == 1);
            applyStimulus(1'b1, 3'b000, 8'h01, 8'h02, 1'b1, 3'b100, 8'h0F, 8'hFF);
            awaitTransaction(expB, expB ? 8'hF0 : 8'h03, 1'b0, 1'b0, expB ? 3'b100 : 3'b000, 0, 1'b0);
        end

        // Backpressure with B waiting, then B granted the cycle after accept.
        $display("[TB] backpressure");
        applyStimulus(1'b1, 3'b101, 8'h3C, 8'h00, 1'b1, 3'b111, 8'h99, 8'h00);
        awaitTransaction(1'b0, 8'hC3, 1'b0, 1'b0, 3'b101, 5, 1'b0);
        applyStimulus(1'b0, 3'b000, 8'h00, 8'h00, 1'b1, 3'b111, 8'h99, 8'h00);
        awaitTransaction(1'b1, 8'h99, 1'b0, 1'b0, 3'b111, 0, 1'b0);

        // Randomized traffic against the reference model.
        $display("[TB] randomized traffic");
        pulseClear();
        stickyModel = 1'b0;
        pendV[0] = 1'b0;
        pendV[1] = 1'b0;
        for (int it = 0; it < 60; it++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pendV[r] && ($urandom_range(0, 1) == 1)) begin
                    pendV[r]  = 1'b1;
                    pendOp[r] = 3'($urandom_range(0, 7));
                    pendX[r]  = 8'($urandom_range(0, 255));
                    pendY[r]  = 8'($urandom_range(0, 255));
                end
            end
            if (!pendV[0] && !pendV[1]) begin
                expB = 1'($urandom_range(0, 1));
                pendV[expB]  = 1'b1;
                pendOp[expB] = 3'($urandom_range(0, 7));
                pendX[expB]  = 8'($urandom_range(0, 255));
                pendY[expB]  = 8'($urandom_range(0, 255));
            end
            applyStimulus(pendV[0], pendOp[0], pendX[0], pendY[0], pendV[1], pendOp[1], pendX[1], pendY[1]);
            expB = (pendV[0] && pendV[1]) ? !lastGrantModel : pendV[1];
            refModel(pendOp[expB], pendX[expB], pendY[expB], res, ovf);
            clr = ($urandom_range(0, 3) == 0);
            stickyModel = ovf ? 1'b1 : (clr ? 1'b0 : stickyModel);
            awaitTransaction(expB, res, ovf, stickyModel, pendOp[expB], int'($urandom_range(0, 3)), clr);
            pendV[expB] = 1'b0;
        end

        applyStimulus(1'b0, 3'b000, 8'h00, 8'h00, 1'b0, 3'b000, 8'h00, 8'h00);
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
